bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 30 +++
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared FSM encoding and default sizing for the bus arbiter.
// The lock watchdog is compiled in by defining BUS_ARB_TIMEOUT_EN.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StOwned  = 2'd1,
        StLocked = 2'd2
    } arb_state_e;

    localparam int unsigned NREQ_DEF     = 4;
    localparam int unsigned W_DEF        = 4;
    localparam int unsigned MAX_HOLD_DEF = 15;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping to 0.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned PW   = idx_width(NREQ_DEF)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned j;
            j = (32'(i_ptr) + i) % NREQ;
            if (!o_any && i_req[j]) begin
                o_any       = 1'b1;
                o_onehot[j] = 1'b1;
                o_idx       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with lock/hold support and a muxed bus output.
// Define BUS_ARB_TIMEOUT_EN to add the lock watchdog and the o_timeout port.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEF,
    parameter int unsigned W        = W_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ-1:0]   i_lock,
    input  logic [NREQ*W-1:0] i_data_in,
    output logic [NREQ-1:0]   o_grant,
    output logic [W-1:0]      o_bus_out,
    output logic              o_bus_valid,
`ifdef BUS_ARB_TIMEOUT_EN
    output logic              o_timeout,
`endif
    output logic              o_locked
);

    localparam int unsigned PW = idx_width(NREQ);

    arb_state_e    r_state;
    logic [NREQ-1:0] r_grant;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_owner;
    logic          r_locked;

    logic [NREQ-1:0] w_pick_req;
    logic [NREQ-1:0] w_pick_oh;
    logic [PW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic [PW-1:0]   w_next_ptr;
    logic            w_hold;
    logic            w_rearb;

    assign w_hold = i_req[r_owner] & i_lock[r_owner];

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] r_hold;
    logic          r_timeout;
    logic          w_force;

    // Forced release fires on the edge that would start locked cycle MAX_HOLD+1.
    assign w_force    = (r_state == StLocked) && w_hold && (r_hold == HW'(MAX_HOLD - 1));
    assign w_pick_req = w_force ? (i_req & ~r_grant) : i_req;
    assign w_rearb    = (r_state == StIdle) || !w_hold || w_force;
    assign o_timeout  = r_timeout;
`else
    assign w_pick_req = i_req;
    assign w_rearb    = (r_state == StIdle) || !w_hold;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .i_req    (w_pick_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_next_ptr = (w_pick_idx == PW'(NREQ - 1)) ? '0 : w_pick_idx + PW'(1);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= StIdle;
            r_grant  <= '0;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_locked <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold    <= '0;
            r_timeout <= 1'b0;
`endif
        end else if (w_rearb) begin
            r_locked <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold    <= '0;
            r_timeout <= w_force;
`endif
            if (w_pick_any) begin
                r_state <= StOwned;
                r_grant <= w_pick_oh;
                r_owner <= w_pick_idx;
                r_ptr   <= w_next_ptr;
            end else begin
                r_state <= StIdle;
                r_grant <= '0;
            end
        end else begin
            // Owner holds req&lock: keep the grant and enter or stay in LOCKED.
            r_state  <= StLocked;
            r_locked <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
            r_hold    <= (r_state == StLocked) ? r_hold + HW'(1) : '0;
`endif
        end
    end

    always_comb begin
        o_bus_out = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                o_bus_out = o_bus_out | i_data_in[i*W +: W];
            end
        end
    end

    assign o_grant     = r_grant;
    assign o_bus_valid = |r_grant;
    assign o_locked    = r_locked;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (default sizing).
// Define BUS_ARB_TIMEOUT_EN to also exercise the lock watchdog.
module tb_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [15:0] data_in;
    logic [3:0]  grant;
    logic [3:0]  bus_out;
    logic        bus_valid;
    logic        locked;
`ifdef BUS_ARB_TIMEOUT_EN
    logic        timeout;
`endif

    int total = 0;
    int bad   = 0;

    bus_arbiter #(
        .NREQ     (4),
        .W        (4),
        .MAX_HOLD (15)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (req),
        .i_lock      (lock),
        .i_data_in   (data_in),
        .o_grant     (grant),
        .o_bus_out   (bus_out),
        .o_bus_valid (bus_valid),
`ifdef BUS_ARB_TIMEOUT_EN
        .o_timeout   (timeout),
`endif
        .o_locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    endtask

    initial begin
        reset   = 1'b0;
        req     = 4'b1111;
        lock    = 4'b0000;
        data_in = 16'h4321;

        // Reset with all requesting
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_bus_out", 32'(bus_out), 32'h0);
        check("rst_valid", 32'(bus_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);

        // Release: round-robin through all four
        reset = 1'b1;
        tick();
        check("rr0_grant", 32'(grant), 32'h1);
        check("rr0_bus", 32'(bus_out), 32'h1);
        tick();
        check("rr1_grant", 32'(grant), 32'h2);
        check("rr1_bus", 32'(bus_out), 32'h2);
        tick();
        check("rr2_grant", 32'(grant), 32'h4);
        tick();
        check("rr3_grant", 32'(grant), 32'h8);
        check("rr3_bus", 32'(bus_out), 32'h4);
        tick();
        check("rr4_grant", 32'(grant), 32'h1);
        check("rr4_valid", 32'(bus_valid), 32'h1);

        // Lock by requester 2
        req     = 4'b0101;
        data_in = 16'h4A21;
        tick();
        check("lk_own_grant", 32'(grant), 32'h4);
        check("lk_own_bus", 32'(bus_out), 32'hA);
        check("lk_own_locked", 32'(locked), 32'h0);
        lock = 4'b0100;
        tick();
        check("lk_grant", 32'(grant), 32'h4);
        check("lk_locked", 32'(locked), 32'h1);
        check("lk_bus", 32'(bus_out), 32'hA);
        tick();
        check("lk_hold_grant", 32'(grant), 32'h4);
        tick();
        check("lk_hold2_grant", 32'(grant), 32'h4);
        check("lk_hold2_locked", 32'(locked), 32'h1);
        lock = 4'b0000;
        tick();
        check("unlk_grant", 32'(grant), 32'h1);
        check("unlk_locked", 32'(locked), 32'h0);

        // Lock without req ignored; lone requester re-granted
        req  = 4'b0001;
        lock = 4'b0010;
        tick();
        check("lone_grant", 32'(grant), 32'h1);
        check("lone_locked", 32'(locked), 32'h0);
        tick();
        check("lone2_grant", 32'(grant), 32'h1);
        check("lone2_locked", 32'(locked), 32'h0);

        // Owner 1 drops req with 3 pending
        lock = 4'b0000;
        req  = 4'b1010;
        tick();
        check("own1_grant", 32'(grant), 32'h2);
        req = 4'b1000;
        tick();
        check("handoff_grant", 32'(grant), 32'h8);
        check("handoff_valid", 32'(bus_valid), 32'h1);

        // No requests -> idle
        req = 4'b0000;
        tick();
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_bus", 32'(bus_out), 32'h0);
        check("idle_valid", 32'(bus_valid), 32'h0);

        // Reset while locked on requester 2 (ptr is nonzero at that point)
        req = 4'b0100;
        tick();
        check("pre_rst_grant", 32'(grant), 32'h4);
        lock = 4'b0100;
        tick();
        check("pre_rst_locked", 32'(locked), 32'h1);
        reset = 1'b0;
        tick();
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_locked", 32'(locked), 32'h0);
        reset = 1'b1;
        lock  = 4'b0000;
        req   = 4'b0101;
        tick();
        check("postrst_ptr0", 32'(grant), 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req   = 4'b0100;
        tick();
        check("postrst_grant", 32'(grant), 32'h4);

`ifdef BUS_ARB_TIMEOUT_EN
        // Watchdog: requester 0 locked, requester 1 waiting
        reset = 1'b0;
        req   = 4'b0011;
        tick();
        reset = 1'b1;
        tick();
        check("to_own_grant", 32'(grant), 32'h1);
        lock = 4'b0001;
        tick();
        check("to_lk_locked", 32'(locked), 32'h1);
        for (int i = 0; i < 14; i++) begin
            tick();
            check("to_hold_grant", 32'(grant), 32'h1);
            check("to_hold_timeout", 32'(timeout), 32'h0);
        end
        tick();
        check("to_fire_timeout", 32'(timeout), 32'h1);
        check("to_fire_grant", 32'(grant), 32'h2);
        check("to_fire_locked", 32'(locked), 32'h0);
        tick();
        check("to_after_timeout", 32'(timeout), 32'h0);
        check("to_after_grant", 32'(grant), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
